// File: rtl/traffic_light_fsm.sv
// Traffic light phase controller for a main-road / side-road intersection.
// It advances on the one-cycle seconds strobe from the Divider. Main green is the
// resting phase and is left only after a side-road or pedestrian request. All
// outputs are registered, so no input reaches an output combinationally.
module traffic_light_fsm #(
  parameter int MAIN_GREEN_S = 10,
  parameter int SIDE_GREEN_S = 6,
  parameter int YELLOW_S     = 3,
  parameter int ALLRED_S     = 1,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oneHz_enable,
  input  logic             side_req,
  input  logic             ped_req,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic [CNT_W-1:0] countdown
);

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALLRED_1,
    SIDE_GREEN,
    SIDE_YELLOW,
    ALLRED_2
  } state_t;

  // Lamp encodings {red,yellow,green}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Countdown load values: each phase shows duration-1 on entry
  localparam logic [CNT_W-1:0] MG_LOAD = CNT_W'(MAIN_GREEN_S - 1);
  localparam logic [CNT_W-1:0] SG_LOAD = CNT_W'(SIDE_GREEN_S - 1);
  localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALLRED_S - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;
  logic             side_pend_reg;
  logic             side_pend_next;
  logic             ped_pend_reg;
  logic             ped_pend_next;
  logic             walk_next;
  logic [2:0]       main_light_next;
  logic [2:0]       side_light_next;
  logic             any_req;

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      MAIN_GREEN:  load_for = MG_LOAD;
      MAIN_YELLOW: load_for = Y_LOAD;
      ALLRED_1:    load_for = AR_LOAD;
      SIDE_GREEN:  load_for = SG_LOAD;
      SIDE_YELLOW: load_for = Y_LOAD;
      ALLRED_2:    load_for = AR_LOAD;
      default:     load_for = MG_LOAD;
    endcase
  endfunction

  // Requests held in the latches or arriving this cycle both count
  assign any_req = side_pend_reg | ped_pend_reg | side_req | ped_req;

  // Next-state, countdown, request latches, walk and lamp decode
  always_comb begin
    state_next      = state_reg;
    cnt_next        = countdown;
    side_pend_next  = side_pend_reg | side_req;
    ped_pend_next   = ped_pend_reg | ped_req;
    walk_next       = walk;
    main_light_next = LAMP_R;
    side_light_next = LAMP_R;

    // Only a tick can move the countdown or the phase
    if (oneHz_enable) begin
      if (countdown != '0) begin
        cnt_next = countdown - 1'b1;
      end else begin
        case (state_reg)
          MAIN_GREEN:  if (any_req) state_next = MAIN_YELLOW;
          MAIN_YELLOW: state_next = ALLRED_1;
          ALLRED_1:    state_next = SIDE_GREEN;
          SIDE_GREEN:  state_next = SIDE_YELLOW;
          SIDE_YELLOW: state_next = ALLRED_2;
          ALLRED_2:    state_next = MAIN_GREEN;
          default:     state_next = MAIN_GREEN;
        endcase
        // Main green at zero with no request simply holds at zero
        if (state_next != state_reg) cnt_next = load_for(state_next);
      end
    end

    // Entering side green consumes all requests, including ones arriving now
    if (state_reg == ALLRED_1 && state_next == SIDE_GREEN) begin
      walk_next      = ped_pend_reg | ped_req;
      side_pend_next = 1'b0;
      ped_pend_next  = 1'b0;
    end else if (state_next != SIDE_GREEN) begin
      walk_next = 1'b0;
    end

    case (state_next)
      MAIN_GREEN:  main_light_next = LAMP_G;
      MAIN_YELLOW: main_light_next = LAMP_Y;
      SIDE_GREEN:  side_light_next = LAMP_G;
      SIDE_YELLOW: side_light_next = LAMP_Y;
      default: begin
        main_light_next = LAMP_R;
        side_light_next = LAMP_R;
      end
    endcase
  end

  // State and output registers; reset overrides any coincident tick or request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MAIN_GREEN;
      countdown     <= MG_LOAD;
      side_pend_reg <= 1'b0;
      ped_pend_reg  <= 1'b0;
      walk          <= 1'b0;
      main_light    <= LAMP_G;
      side_light    <= LAMP_R;
    end else begin
      state_reg     <= state_next;
      countdown     <= cnt_next;
      side_pend_reg <= side_pend_next;
      ped_pend_reg  <= ped_pend_next;
      walk          <= walk_next;
      main_light    <= main_light_next;
      side_light    <= side_light_next;
    end
  end

endmodule
